load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Memory stage placed directly after the execute stage. Takes the ALU result as the address and rs2 as the store data.
//  Drives a req/gnt/rvalid data-memory port and formats load data (byte lanes, sign/zero extension) for writeback.
//  Holds upstream with lsu_stall while a bus access is outstanding. Non-memory ops pass through with one register delay.
// PARAMETERS
//  XLEN     32  datapath width; only 32 is supported.
//  TIMEOUT  16  max cycles spent in REQ+WAIT before bus_err is raised; must be >=2.
// PORTS
//  clk          in   1     clock; all state updates on the rising edge.
//  rst_n        in   1     asynchronous reset, active-low.
//  ex_valid     in   1     execute-stage output is valid this cycle.
//  mem_read     in   1     load instruction.
//  mem_write    in   1     store instruction; mem_read & mem_write together is illegal.
//  funct3       in   3     RV32 load/store width and sign field.
//  addr         in   32    effective address (execute result).
//  store_data   in   32    rs2 value.
//  rd_in        in   5     destination register.
//  lsu_stall    out  1     combinational: state!=IDLE.
//  wb_valid     out  1     1-cycle pulse: wb_data/wb_rd are valid.
//  wb_data      out  32    load data, or the passed-through execute result.
//  wb_rd        out  5     destination register; forced to 0 for stores.
//  misalign     out  1     1-cycle pulse: misaligned address or illegal funct3.
//  bus_err      out  1     1-cycle pulse: access timed out.
//  dmem_req     out  1     memory request; held until dmem_gnt.
//  dmem_we      out  1     1 = write.
//  dmem_addr    out  32    word address ({addr[31:2],2'b00}).
//  dmem_wdata   out  32    lane-replicated store data.
//  dmem_be      out  4     byte enables.
//  dmem_gnt     in   1     request accepted.
//  dmem_rvalid  in   1     read data valid; arrives >=1 cycle after gnt.
//  dmem_rdata   in   32    read data.
// BEHAVIOUR
//  Reset: state=IDLE, counter=0, all registered outputs and dmem_* = 0.
//  Accept: IDLE & ex_valid. Latch addr, funct3, data and rd. Non-mem ops -> wb_valid=1 and wb_data=addr on the next cycle.
//  Checks: LH/LHU/SH need addr[0]=0; LW/SW need addr[1:0]=0.
//  Illegal funct3: loads 3, 6, 7; stores >2. Error -> misalign pulse next cycle, no bus access, no wb_valid, stay IDLE.
//  FSM: IDLE -> REQ (dmem_req=1, signals stable).
//    REQ & gnt: store -> IDLE with wb_valid (wb_rd=0); load -> WAIT.
//    WAIT & rvalid -> IDLE; wb_valid and formatted data on the next edge.
//  rvalid is ignored outside WAIT; gnt is ignored outside REQ.
//  Latency, zero-wait memory: store accept->wb_valid 2 cycles; load 3 cycles.
//  dmem_be: SB 4'b0001<<a[1:0]; SH 4'b0011<<a[1:0]; SW 4'b1111.
//  dmem_wdata: SB {4{d[7:0]}}; SH {2{d[15:0]}}; SW d.
//  Load formatting: byte/half selected by a[1:0].
//    LB/LH sign-extend; LBU/LHU zero-extend; LW full word.
//  Timeout: counter clears on entry to REQ and runs through REQ+WAIT.
//    Reaching TIMEOUT -> bus_err pulse, dmem_req=0, IDLE, no wb_valid.
//  Async reset mid-access: abandon the transaction and return to IDLE; a late rvalid is ignored.
// STRUCTURE
//  Shared header lsu_defs.vh: funct3 localparams (LB..SW), FSM state encodings (IDLE/REQ/WAIT).
//  Sub-module lsu_load_align: combinational (rdata, a[1:0], funct3) -> 32-bit formatted load data.
// TESTING
//  1. Non-mem op, addr=32'h1234 -> wb_valid 1 cycle later, wb_data=32'h1234, lsu_stall never high.
//  2. SB a=0x103, d=0xAB, gnt same cycle -> be=4'b1000, wdata=0xABABABAB, dmem_addr=0x100, wb_rd=0.
//  3. LB a=0x101, rdata=0x0000_8000 -> wb_data=0xFFFF_FF80; LBU same -> 0x0000_0080.
//  4. LH a=0x003 -> misalign pulse, dmem_req stays 0, no wb_valid.
//  5. gnt withheld 4 cycles, rvalid 2 cycles later -> dmem_req held 5 cycles, stall until WAIT exits, correct data.
//  6. No gnt for TIMEOUT cycles -> bus_err pulse, IDLE. Separately: rst_n low in WAIT then rvalid -> no wb_valid.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: funct3 encodings, FSM states and byte-lane helpers shared by the load/store unit.
package load_store_unit_pkg;
    localparam logic [2:0] LB  = 3'd0;
    localparam logic [2:0] LH  = 3'd1;
    localparam logic [2:0] LW  = 3'd2;
    localparam logic [2:0] LBU = 3'd4;
    localparam logic [2:0] LHU = 3'd5;
    localparam logic [2:0] SB  = 3'd0;
    localparam logic [2:0] SH  = 3'd1;
    localparam logic [2:0] SW  = 3'd2;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    // Illegal width code or an address not aligned to the access size.
    function automatic logic access_bad(input logic store, input logic [2:0] f3, input logic [1:0] a);
        return (store ? f3 > SW : (f3 == 3'd3 || f3 > LHU)) ||
               (f3[1:0] == LH[1:0] && a[0]) || (f3[1:0] == LW[1:0] && a != 2'b00);
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] a);
        return f3[1:0] == SB[1:0] ? 4'b0001 << a : f3[1:0] == SH[1:0] ? 4'b0011 << a : 4'b1111;
    endfunction

    function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] d);
        return f3[1:0] == SB[1:0] ? {4{d[7:0]}} : f3[1:0] == SH[1:0] ? {2{d[15:0]}} : d;
    endfunction
endpackage

// File: rtl/load_store_unit_load_align.sv
// load_store_unit_load_align: selects the addressed byte/half of a read word and sign/zero extends it.
module load_store_unit_load_align
    import load_store_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  a,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);
    logic [15:0] sh;

    assign sh = 16'(rdata >> {a, 3'b000});

    always_comb
        data = funct3 == LB  ? {{24{sh[7]}}, sh[7:0]} :
               funct3 == LBU ? {24'b0, sh[7:0]} :
               funct3 == LH  ? {{16{sh[15]}}, sh} :
               funct3 == LHU ? {16'b0, sh} : rdata;
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: memory stage driving a req/gnt/rvalid data port and formatting load data for writeback.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] store_data,
    input  logic [4:0]      rd_in,
    output logic            lsu_stall,
    output logic            wb_valid,
    output logic [XLEN-1:0] wb_data,
    output logic [4:0]      wb_rd,
    output logic            misalign,
    output logic            bus_err,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_be,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata
);
    localparam int CW = $clog2(TIMEOUT);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            ld;
    logic [1:0]      a_lo;
    logic [2:0]      f3;
    logic [4:0]      rd;
    logic [XLEN-1:0] ld_data;
    logic            bad;
    logic            done;

    assign lsu_stall = state != IDLE;
    assign bad       = (mem_read & mem_write) | access_bad(mem_write, funct3, addr[1:0]);
    // A store finishes on its grant; a load only once its read data returns.
    assign done      = state == REQ ? dmem_gnt & ~ld : (state == WAIT) & dmem_rvalid;

    load_store_unit_load_align u_align (
        .rdata  (dmem_rdata),
        .a      (a_lo),
        .funct3 (f3),
        .data   (ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            ld         <= 1'b0;
            a_lo       <= '0;
            f3         <= '0;
            rd         <= '0;
            wb_valid   <= 1'b0;
            wb_data    <= '0;
            wb_rd      <= '0;
            misalign   <= 1'b0;
            bus_err    <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_be    <= '0;
        end else begin
            wb_valid <= 1'b0;
            misalign <= 1'b0;
            bus_err  <= 1'b0;
            if (state == IDLE) begin
                if (ex_valid && !(mem_read || mem_write)) begin
                    wb_valid <= 1'b1;
                    wb_data  <= addr;
                    wb_rd    <= rd_in;
                end else if (ex_valid && bad) begin
                    misalign <= 1'b1;
                end else if (ex_valid) begin
                    state      <= REQ;
                    cnt        <= '0;
                    ld         <= mem_read;
                    a_lo       <= addr[1:0];
                    f3         <= funct3;
                    rd         <= rd_in;
                    dmem_req   <= 1'b1;
                    dmem_we    <= mem_write;
                    dmem_addr  <= {addr[XLEN-1:2], 2'b00};
                    dmem_wdata <= lane_data(funct3, store_data);
                    dmem_be    <= byte_en(funct3, addr[1:0]);
                end
            end else if (done) begin
                state    <= IDLE;
                dmem_req <= 1'b0;
                wb_valid <= 1'b1;
                wb_data  <= ld ? ld_data : '0;
                wb_rd    <= ld ? rd : '0;
            end else if (cnt == CW'(TIMEOUT - 1)) begin
                state    <= IDLE;
                dmem_req <= 1'b0;
                bus_err  <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
                if (state == REQ && dmem_gnt) begin
                    state    <= WAIT;
                    dmem_req <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: random and directed load/store/non-mem traffic against a byte-level memory model.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] addr = '0;
    logic [31:0] store_data = '0;
    logic [4:0]  rd_in = '0;
    logic        lsu_stall;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        misalign;
    logic        bus_err;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt = 1'b0;
    logic        dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = '0;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem [16];

    always #5 clk = ~clk;

    load_store_unit #(.XLEN(32), .TIMEOUT(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ex_valid    (ex_valid),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .funct3      (funct3),
        .addr        (addr),
        .store_data  (store_data),
        .rd_in       (rd_in),
        .lsu_stall   (lsu_stall),
        .wb_valid    (wb_valid),
        .wb_data     (wb_data),
        .wb_rd       (wb_rd),
        .misalign    (misalign),
        .bus_err     (bus_err),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_be     (dmem_be),
        .dmem_gnt    (dmem_gnt),
        .dmem_rvalid (dmem_rvalid),
        .dmem_rdata  (dmem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // kind: 0 = non-memory, 1 = load, 2 = store
    function automatic bit is_bad(input int kind, input logic [2:0] f3, input logic [31:0] a);
        int size = 1 << f3[1:0];
        bit ill  = kind == 2 ? f3 > 3'd2 : (f3 == 3'd3 || f3 > 3'd5);
        return ill || (a % size != 0);
    endfunction

    task automatic op(input int kind, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                      input logic [4:0] rd, input int gdly, input int rdly);
        int          size = 1 << f3[1:0];
        int          off  = int'(a[1:0]);
        int          idx  = int'(a[5:2]);
        int          n    = 0;
        logic [3:0]  be   = '0;
        logic [31:0] wd   = '0;
        logic [31:0] v    = '0;
        logic [31:0] ones = '1;
        check("idle_stall", 32'(lsu_stall), 0);
        ex_valid   = 1'b1;
        mem_read   = kind == 1;
        mem_write  = kind == 2;
        funct3     = f3;
        addr       = a;
        store_data = d;
        rd_in      = rd;
        @(negedge clk);
        ex_valid  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        addr      = $urandom;
        if (kind == 0) begin
            check("pass_valid", 32'(wb_valid), 1);
            check("pass_data", wb_data, a);
            check("pass_rd", 32'(wb_rd), 32'(rd));
            check("pass_stall", 32'(lsu_stall), 0);
            return;
        end
        if (is_bad(kind, f3, a)) begin
            check("misalign", 32'(misalign), 1);
            check("err_noreq", 32'(dmem_req), 0);
            check("err_nowb", 32'(wb_valid), 0);
            check("err_stall", 32'(lsu_stall), 0);
            return;
        end
        check("req_stall", 32'(lsu_stall), 1);
        check("req_addr", dmem_addr, a & ~32'h3);
        check("req_we", 32'(dmem_we), kind == 2 ? 1 : 0);
        if (kind == 2) begin
            for (int j = 0; j < 4; j++) begin
                be[j]        = j >= off && j < off + size;
                wd[8*j +: 8] = d[8*(j % size) +: 8];
            end
            check("store_be", 32'(dmem_be), 32'(be));
            check("store_wdata", dmem_wdata, wd);
        end
        for (int i = 0; i <= gdly; i++) begin
            n += int'(dmem_req);
            dmem_gnt    = i == gdly;
            dmem_rvalid = i < gdly && $urandom % 2 == 1;
            dmem_rdata  = $urandom;
            @(negedge clk);
        end
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        check("req_hold", 32'(n), 32'(gdly + 1));
        check("req_drop", 32'(dmem_req), 0);
        if (kind == 2) begin
            check("store_wb", 32'(wb_valid), 1);
            check("store_rd", 32'(wb_rd), 0);
            check("store_stall", 32'(lsu_stall), 0);
            for (int k = 0; k < size; k++) mem[idx][8*(off+k) +: 8] = d[8*k +: 8];
            return;
        end
        for (int i = 1; i <= rdly; i++) begin
            check("wait_stall", 32'(lsu_stall), 1);
            check("wait_nowb", 32'(wb_valid), 0);
            dmem_rvalid = i == rdly;
            dmem_rdata  = i == rdly ? mem[idx] : $urandom;
            @(negedge clk);
        end
        dmem_rvalid = 1'b0;
        for (int k = 0; k < size; k++) v[8*k +: 8] = mem[idx][8*(off+k) +: 8];
        if (f3 < 3'd4 && size < 4 && v[8*size-1]) v = v | (ones << (8 * size));
        check("load_wb", 32'(wb_valid), 1);
        check("load_data", wb_data, v);
        check("load_rd", 32'(wb_rd), 32'(rd));
        check("load_stall", 32'(lsu_stall), 0);
    endtask

    task automatic settle();
        @(negedge clk);
        check("pulses_clear", 32'({wb_valid, misalign, bus_err}), 0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        repeat (2) @(negedge clk);
        check("rst_ctrl", 32'({lsu_stall, wb_valid, misalign, bus_err, dmem_req, dmem_we, dmem_be}), 0);
        check("rst_data", wb_data | dmem_addr | dmem_wdata | 32'(wb_rd), 0);
        rst_n = 1'b1;
        @(negedge clk);

        op(0, 3'd0, 32'h1234, 0, 5'd3, 0, 1);
        settle();
        op(2, 3'd0, 32'h103, 32'hAB, 5'd9, 0, 1);
        settle();
        mem[0] = 32'h0000_8000;
        op(1, 3'd0, 32'h101, 0, 5'd4, 0, 1);
        settle();
        op(1, 3'd4, 32'h101, 0, 5'd5, 0, 1);
        settle();
        op(1, 3'd1, 32'h003, 0, 5'd6, 0, 1);
        settle();
        op(1, 3'd2, 32'h108, 0, 5'd7, 4, 2);
        settle();

        for (int t = 0; t < 80; t++) begin
            op($urandom % 3, 3'($urandom % 8), 32'h100 + ($urandom % 64), $urandom,
               5'($urandom % 32), $urandom % 5, 1 + $urandom % 3);
            settle();
        end

        ex_valid = 1'b1;
        mem_read = 1'b1;
        funct3   = 3'd2;
        addr     = 32'h10C;
        @(negedge clk);
        ex_valid = 1'b0;
        mem_read = 1'b0;
        n = 0;
        while (dmem_req && n < 40) begin
            n++;
            check("tmo_noerr", 32'(bus_err), 0);
            @(negedge clk);
        end
        check("tmo_cycles", 32'(n), 16);
        check("tmo_bus_err", 32'(bus_err), 1);
        check("tmo_nowb", 32'(wb_valid), 0);
        check("tmo_idle", 32'(lsu_stall), 0);
        settle();

        ex_valid = 1'b1;
        mem_read = 1'b1;
        funct3   = 3'd2;
        addr     = 32'h104;
        @(negedge clk);
        ex_valid = 1'b0;
        mem_read = 1'b0;
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        check("rst_in_wait", 32'(lsu_stall), 1);
        rst_n = 1'b0;
        #1;
        check("rst_async", 32'({lsu_stall, dmem_req, wb_valid}), 0);
        @(negedge clk);
        rst_n       = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        check("late_rvalid", 32'(wb_valid), 0);
        check("late_idle", 32'(lsu_stall), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
